// File: rtl/feature_map_stream_reader.sv
// Feature-map RAM read client. It sweeps a run of word addresses and issues one read per word.
// Each PARA_Y-element word is serialised into a one-element-per-beat valid/ready stream.
module feature_map_stream_reader #(
   parameter int DATA_WIDTH      = 16,
   parameter int PARA_Y          = 3,
   parameter int READ_ADDR_WIDTH = 4,
   parameter int MAX_ADDR        = 7,
   parameter int LEN_WIDTH       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [READ_ADDR_WIDTH-1:0]   base_addr,
   input  logic [LEN_WIDTH-1:0]         num_words,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         ram_rd_req,
   output logic [READ_ADDR_WIDTH-1:0]   ram_addr_read,
   input  logic [PARA_Y*DATA_WIDTH-1:0] ram_dout,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_last
);

   localparam int IDX_W = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;
   localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(PARA_Y - 1);
   localparam logic [READ_ADDR_WIDTH:0] MAX_ADDR_L = (READ_ADDR_WIDTH + 1)'(MAX_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t                              state;
   logic [READ_ADDR_WIDTH-1:0]          cur_addr;
   logic [LEN_WIDTH-1:0]                words_left;
   logic [IDX_W-1:0]                    elem_idx;
   logic [PARA_Y-1:0][DATA_WIDTH-1:0]   hold;

   logic [READ_ADDR_WIDTH-1:0]          next_addr;
   logic [IDX_W-1:0]                    idx_next;
   logic                                addr_ok;
   logic                                base_ok;
   logic                                next_ok;
   logic                                last_word;
   logic                                beat_fire;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_addr = cur_addr + 1'b1;
      idx_next  = elem_idx + 1'b1;
      addr_ok   = ({1'b0, cur_addr}  < MAX_ADDR_L);
      base_ok   = ({1'b0, base_addr} < MAX_ADDR_L);
      next_ok   = ({1'b0, next_addr} < MAX_ADDR_L);
      last_word = (words_left == LEN_WIDTH'(1));
      beat_fire = m_valid && m_ready;
   end

   // NOTE: the element holding register is a pure datapath buffer that is always reloaded
   // before it is read, so it is left without reset.
   always_ff @(posedge clk) begin
      if (state == S_CAPTURE) hold <= ram_dout;
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cur_addr      <= '0;
         words_left    <= '0;
         elem_idx      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         ram_rd_req    <= 1'b0;
         ram_addr_read <= '0;
         m_valid       <= 1'b0;
         m_data        <= '0;
         m_last        <= 1'b0;
      end else begin
         done       <= 1'b0;
         ram_rd_req <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr   <= base_addr;
                  words_left <= num_words;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  if (num_words == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     // The read request is registered, so the range check is decided on entry to ISSUE.
                     state      <= S_ISSUE;
                     ram_rd_req <= base_ok;
                     if (base_ok) ram_addr_read <= base_addr;
                  end
               end
            end
            S_ISSUE: begin
               if (!addr_ok) begin
                  err   <= 1'b1;
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               state    <= S_SHIFT;
               elem_idx <= '0;
               m_valid  <= 1'b1;
               m_data   <= ram_dout[DATA_WIDTH-1:0];
               m_last   <= (LAST_IDX == '0) && last_word;
            end
            S_SHIFT: begin
               if (beat_fire) begin
                  if (elem_idx == LAST_IDX) begin
                     m_valid    <= 1'b0;
                     m_last     <= 1'b0;
                     words_left <= words_left - 1'b1;
                     if (!last_word) begin
                        state      <= S_ISSUE;
                        cur_addr   <= next_addr;
                        ram_rd_req <= next_ok;
                        if (next_ok) ram_addr_read <= next_addr;
                     end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  end else begin
                     elem_idx <= idx_next;
                     m_data   <= hold[idx_next];
                     m_last   <= (idx_next == LAST_IDX) && last_word;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_feature_map_stream_reader.sv
// Table-driven bench for feature_map_stream_reader with a 1-cycle-latency RAM model.
// It also runs hand-written sequences for sticky error, ignored start and mid-run reset.
module tb_feature_map_stream_reader;

   localparam int DW = 16;
   localparam int P  = 3;
   localparam int AW = 4;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [AW-1:0]   base_addr;
   logic [LW-1:0]   num_words;
   logic            busy, done, err, ram_rd_req;
   logic [AW-1:0]   ram_addr_read;
   logic [P*DW-1:0] ram_dout;
   logic            m_valid, m_ready, m_last;
   logic [DW-1:0]   m_data;

   int checks   = 0;
   int failures = 0;

   feature_map_stream_reader #(
      .DATA_WIDTH(DW), .PARA_Y(P), .READ_ADDR_WIDTH(AW), .MAX_ADDR(7), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
      .busy(busy), .done(done), .err(err), .ram_rd_req(ram_rd_req),
      .ram_addr_read(ram_addr_read), .ram_dout(ram_dout), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] elem(input int i);
      return 16'hA000 + DW'(i);
   endfunction

   // RAM model: each element holds a tag of its flat RAM index; one cycle read latency.
   initial ram_dout = '0;
   always @(posedge clk) begin
      if (ram_rd_req)
         for (int k = 0; k < P; k++) ram_dout[k*DW +: DW] <= elem(int'(ram_addr_read) * P + k);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [LW-1:0] num;
      bit            bp;          // m_ready pattern 1,0,0,1 instead of constant 1
      int            spur;        // cycle at which a stray start is pulsed (0 = none)
      int            exp_beats;
      bit            exp_last;
      bit            exp_err;
      int            exp_rd;
      int            exp_done;    // done cycle, 0 = not checked
      int            exp_first;   // first m_valid cycle, 0 = not checked
   } vec_t;

   vec_t tbl[9];

   task automatic run_case(input int id, input vec_t v);
      int  beats = 0, lasts = 0, rdreqs = 0, first_v = 0, done_cyc = 0;
      bit  got_done = 0;
      logic          p_stall = 1'b0, p_last = 1'b0;
      logic [DW-1:0] p_data = '0;
      logic [AW-1:0] ea;
      bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      start = 1'b1; base_addr = v.base; num_words = v.num; m_ready = 1'b1;
      for (int cyc = 1; cyc < 200 && !got_done; cyc++) begin
         @(negedge clk);
         start = (cyc == v.spur);
         if (cyc == v.spur) begin base_addr = 4'd3; num_words = 4'd1; end
         m_ready = v.bp ? pat[cyc % 4] : 1'b1;
         if (cyc == 1) check($sformatf("c%0d busy_c1", id), busy, 1);
         if (p_stall) begin
            check($sformatf("c%0d stall_valid", id), m_valid, 1);
            check($sformatf("c%0d stall_data", id), m_data, p_data);
            check($sformatf("c%0d stall_last", id), m_last, p_last);
         end
         if (ram_rd_req) begin
            ea = v.base + AW'(rdreqs);
            check($sformatf("c%0d rd_addr", id), ram_addr_read, ea);
            rdreqs++;
         end
         if (m_valid && first_v == 0) first_v = cyc;
         if (m_valid && m_ready) begin
            check($sformatf("c%0d beat%0d", id, beats), m_data, elem(int'(v.base) * P + beats));
            check($sformatf("c%0d last%0d", id, beats), m_last,
                  (v.exp_last && beats == v.exp_beats - 1) ? 1 : 0);
            if (m_last) lasts++;
            beats++;
         end
         p_stall = m_valid && !m_ready;
         p_data  = m_data;
         p_last  = m_last;
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
            check($sformatf("c%0d err_at_done", id), err, v.exp_err);
         end
      end
      start = 1'b0;
      if (!got_done) check($sformatf("c%0d done_timeout", id), 0, 1);
      check($sformatf("c%0d beats", id), beats, v.exp_beats);
      check($sformatf("c%0d lasts", id), lasts, v.exp_last ? 1 : 0);
      check($sformatf("c%0d rd_reqs", id), rdreqs, v.exp_rd);
      if (v.exp_done != 0) check($sformatf("c%0d done_cycle", id), done_cyc, v.exp_done);
      if (v.exp_first != 0) check($sformatf("c%0d first_valid", id), first_v, v.exp_first);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("c%0d idle_busy", id), busy, 0);
         check($sformatf("c%0d idle_done", id), done, 0);
         check($sformatf("c%0d idle_valid", id), m_valid, 0);
         check($sformatf("c%0d err_sticky", id), err, v.exp_err);
      end
   endtask

   initial begin
      tbl[0] = '{4'd0,  4'd1, 1'b0, 0, 3, 1'b1, 1'b0, 1, 6,  3};
      tbl[1] = '{4'd2,  4'd3, 1'b0, 0, 9, 1'b1, 1'b0, 3, 16, 3};
      tbl[2] = '{4'd1,  4'd2, 1'b1, 0, 6, 1'b1, 1'b0, 2, 0,  3};
      tbl[3] = '{4'd5,  4'd4, 1'b0, 0, 6, 1'b0, 1'b1, 2, 12, 3};
      tbl[4] = '{4'd0,  4'd0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1,  0};
      tbl[5] = '{4'd9,  4'd1, 1'b0, 0, 0, 1'b0, 1'b1, 0, 2,  0};
      tbl[6] = '{4'd6,  4'd1, 1'b0, 0, 3, 1'b1, 1'b0, 1, 6,  3};
      tbl[7] = '{4'd0,  4'd2, 1'b0, 4, 6, 1'b1, 1'b0, 2, 11, 3};
      tbl[8] = '{4'd0,  4'd1, 1'b0, 6, 3, 1'b1, 1'b0, 1, 6,  3};

      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; m_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rd_req", ram_rd_req, 0);
      check("rst_valid", m_valid, 0);
      check("rst_last", m_last, 0);
      check("rst_addr", ram_addr_read, 0);
      check("rst_data", m_data, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         if (i == 4) check("err_before_restart", err, 1);
         run_case(i, tbl[i]);
      end

      // Reset asserted while a beat is presented.
      @(negedge clk);
      start = 1'b1; base_addr = 4'd1; num_words = 4'd2; m_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_valid_before_rst", m_valid, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", m_data, 0);
      check("mid_rst_addr", ram_addr_read, 0);
      check("mid_rst_last", m_last, 0);
      @(negedge clk);
      rst = 1'b0; m_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_valid", m_valid, 0);
         check("post_rst_rd_req", ram_rd_req, 0);
      end
      run_case(9, '{4'd1, 4'd1, 1'b0, 0, 3, 1'b1, 1'b0, 1, 6, 3});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
